// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared constants, state encoding and helpers for timer_counter
package timer_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  localparam int EN       = 0;
  localparam int MODE_LSB = 1;
  localparam int IM       = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_AUTO    = 2'd1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  function automatic logic [31:0] ctrl_word(input logic [3:0] ctrl);
    return {28'b0, ctrl};
  endfunction

endpackage

// File: rtl/timer_be_merge.sv
// rtl/timer_be_merge.sv - byte-enable merge of a register's old value with write data
module timer_be_merge (
  input  logic [31:0] old_val,
  input  logic [31:0] wdata,
  input  logic [3:0]  we,
  output logic [31:0] merged
);

  always_comb begin
    merged = old_val;
    for (int i = 0; i < 4; i++) begin
      if (we[i]) merged[i*8 +: 8] = wdata[i*8 +: 8];
    end
  end

endmodule

// File: rtl/timer_counter.sv
// rtl/timer_counter.sv - memory-mapped 32-bit down-counting timer with level interrupt
module timer_counter
  import timer_pkg::*;
#(
  parameter logic [31:0] PRESET_RESET = 32'h0000_0000,
  parameter bit          IRQ_PULSE_M1 = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  Addr,
  input  logic [31:0] WData,
  input  logic [3:0]  WE,
  output logic [31:0] RData,
  output logic        IRQ
);

  state_t      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        pend_q, pend_d;

  logic        wr_any, wr_ctrl, wr_preset;
  logic        mode_auto;
  logic [31:0] ctrl_merged, preset_merged;
  logic        ctrl_hi_unused;

  assign wr_any    = |WE;
  assign wr_ctrl   = wr_any && (Addr == ADDR_CTRL);
  assign wr_preset = wr_any && (Addr == ADDR_PRESET);
  assign mode_auto = (ctrl_q[MODE_LSB +: 2] == MODE_AUTO);

  timer_be_merge u_ctrl_merge (
    .old_val (ctrl_word(ctrl_q)),
    .wdata   (WData),
    .we      (WE),
    .merged  (ctrl_merged)
  );

  timer_be_merge u_preset_merge (
    .old_val (preset_q),
    .wdata   (WData),
    .we      (WE),
    .merged  (preset_merged)
  );

  // CTRL[31:4] do not exist; written bits there are simply dropped.
  assign ctrl_hi_unused = ^ctrl_merged[31:4];

  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    pend_d   = pend_q;

    if (wr_ctrl)   ctrl_d   = ctrl_merged[3:0];
    if (wr_preset) preset_d = preset_merged;
    if (wr_ctrl || wr_preset) pend_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ctrl_q[EN]) state_d = S_LOAD;
      end
      S_LOAD: begin
        count_d = preset_q;
        state_d = S_CNT;
      end
      S_CNT: begin
        if (!ctrl_q[EN]) begin
          state_d = S_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          // Setting pend here takes priority over a same-cycle write-clear.
          count_d = 32'd0;
          pend_d  = 1'b1;
          state_d = S_INT;
        end
      end
      S_INT: begin
        state_d = S_IDLE;
        if (mode_auto) begin
          if (IRQ_PULSE_M1) pend_d = 1'b0;
        end else if (!wr_ctrl) begin
          ctrl_d[EN] = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ctrl_q   <= 4'd0;
      preset_q <= PRESET_RESET;
      count_q  <= 32'd0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
    end
  end

  always_comb begin
    RData = 32'd0;
    case (Addr)
      ADDR_CTRL:   RData = ctrl_word(ctrl_q);
      ADDR_PRESET: RData = preset_q;
      ADDR_COUNT:  RData = count_q;
      default:     RData = 32'd0;
    endcase
  end

  assign IRQ = ctrl_q[IM] & pend_q;

endmodule
